multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Parametrised successor to the single-channel `timer`: CHANNELS independent down-count timers sharing one programmable prescaler.
- Each channel can be one-shot or auto-reload, stopped, or restarted, and exposes its live count.
- Expiry produces a one-cycle `timer_over` pulse plus a sticky status bit ORed into a single `irq`.
- Used as the general-purpose timing resource feeding control FSMs and interrupt logic.

Parameters:
WIDTH, 8, count/period width per channel
CHANNELS, 4, number of independent timer channels
PRESCALE_W, 4, width of prescaler divide value

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
timer_circle  input  CHANNELS*WIDTH  per-channel period value N, channel i at [i*WIDTH +: WIDTH]
start_flag  input  CHANNELS  per-channel start/restart request, level sampled each cycle
stop_flag  input  CHANNELS  per-channel stop request
mode  input  CHANNELS  0 = one-shot, 1 = auto-reload; sampled at start
prescale  input  PRESCALE_W  tick every prescale+1 clocks
irq_clr  input  CHANNELS  clear sticky status bit
timer_over  output  CHANNELS  one-cycle expiry pulse per channel
busy  output  CHANNELS  channel in RUN state
timer_value  output  CHANNELS*WIDTH  live count per channel
status  output  CHANNELS  sticky expiry flags
irq  output  1  OR of status

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, prescaler counter 0, all channels IDLE, latched periods and modes 0.
- Prescaler:
  - Free-running counter `pre_cnt`.
  - `tick` is 1 when pre_cnt >= prescale; `pre_cnt` then returns to 0, otherwise it increments.
  - prescale=0 gives tick every cycle.
  - Reducing prescale below `pre_cnt` causes a tick on the next cycle; it never waits for wrap.
- Per-channel FSM, two states, IDLE and RUN:
  - IDLE, start_flag=1, stop_flag=0: latch timer_circle into period and count; latch mode; go to RUN. This happens regardless of tick.
  - RUN, tick=1, count≠0: count decrements by 1.
  - RUN, tick=1, count=0: timer_over is registered high for the next cycle and status is set.
    - In auto-reload mode, count reloads from the latched period and the channel stays in RUN.
    - In one-shot mode, the channel goes to IDLE.
  - RUN, start_flag=1: restart. Reload from the current timer_circle and mode; no timer_over, even if a tick and count=0 occur in the same cycle.
  - stop_flag=1 in any state: go to IDLE and hold the count; no timer_over. When stop and start are asserted together, stop wins.
- Timing:
  - With prescale=0, start sampled at edge k with N: timer_over is high in the cycle after edge k+N+1, i.e. N+1 ticks.
  - Auto-reload period is N+1 ticks.
  - N=0 expires on the first tick.
  - With prescale>0, first-tick latency after start is 1..prescale+1 clocks because the prescaler is not synchronised to start.
- Holding start_flag high keeps a channel restarting every cycle, so it never expires.
- Wrap-around: no underflow. count=0 always expires or reloads and is never decremented.
- Status and irq:
  - status[i] is set by expiry and cleared by irq_clr[i]; set wins when both occur in the same cycle.
  - irq = |status, registered, one cycle after status.
- busy[i] = (state==RUN).
- timer_value always reflects the registered count, including in IDLE after a stop.
- Reset mid-count: immediate return to reset values; no pulse.
- Channels are fully independent; simultaneous expiries on several channels all pulse in the same cycle.

Test Plan:
- Prescale=0, ch0 one-shot, N=5, start for 1 cycle -> timer_over[0] high for exactly 1 cycle, 6 cycles after the start edge; busy[0] falls at the same edge; timer_value[0]=0.
- Prescale=3, ch1 auto-reload, N=2 -> timer_over[1] pulses every 12 clocks, at least 3 times; status[1]=1 and irq=1 after the first pulse; irq_clr[1] clears both, and status re-sets on the next pulse.
- Prescale=0, ch2 N=10; stop asserted at count=4 -> busy[2]=0, timer_value[2] holds 4, no timer_over; a later start with N=0 -> pulse 1 cycle after the next tick.
- Ch3 running N=8; restart with N=3 when count=1 -> no pulse from the old run; pulse 4 ticks after the restart; stop+start asserted together -> IDLE.
- All 4 channels started in the same cycle with N=7 in auto-reload; RST dropped mid-count -> simultaneous pulses on all 4 before the reset; after the reset, all outputs 0 immediately and no pulse until the next start.
- irq_clr[0] coinciding with an expiry on ch0 -> status[0] remains 1.

Source files
------------

// File: rtl/multi_timer_if.sv
// Bus bundle for multi_timer: per-channel period/control inputs and timer
// status outputs. CLK and RST stay as plain ports on the timer itself.
interface multi_timer_if #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 4,
   parameter int PRESCALE_W = 4
);
   logic [CHANNELS*WIDTH-1:0] timer_circle;
   logic [CHANNELS-1:0]       start_flag;
   logic [CHANNELS-1:0]       stop_flag;
   logic [CHANNELS-1:0]       mode;
   logic [PRESCALE_W-1:0]     prescale;
   logic [CHANNELS-1:0]       irq_clr;
   logic [CHANNELS-1:0]       timer_over;
   logic [CHANNELS-1:0]       busy;
   logic [CHANNELS*WIDTH-1:0] timer_value;
   logic [CHANNELS-1:0]       status;
   logic                      irq;

   modport master (
      output timer_circle, start_flag, stop_flag, mode, prescale, irq_clr,
      input  timer_over, busy, timer_value, status, irq
   );

   modport slave (
      input  timer_circle, start_flag, stop_flag, mode, prescale, irq_clr,
      output timer_over, busy, timer_value, status, irq
   );
endinterface

// File: rtl/multi_timer.sv
// CHANNELS independent down-count timers sharing one free-running prescaler,
// with one-cycle expiry pulses, sticky status bits and a combined irq.
//
// state   | meaning
// IDLE    | channel stopped, count held, waiting for start_flag
// RUN     | channel counting down on each prescaler tick
module multi_timer #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 4,
   parameter int PRESCALE_W = 4
) (
   input  logic         CLK,
   input  logic         RST,
   multi_timer_if.slave bus
);
   localparam logic [0:0]            ST_IDLE  = 1'b0;
   localparam logic [0:0]            ST_RUN   = 1'b1;
   localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   logic [PRESCALE_W-1:0]     pre_cnt_q, pre_cnt_d;
   logic                      tick;
   logic [CHANNELS-1:0]       state_q, state_d;
   logic [CHANNELS-1:0]       mode_q, mode_d;
   logic [CHANNELS-1:0]       over_q, over_d;
   logic [CHANNELS-1:0]       status_q, status_d;
   logic                      irq_q, irq_d;
   logic [CHANNELS*WIDTH-1:0] count_q, count_d;
   logic [CHANNELS*WIDTH-1:0] period_q, period_d;

   // Compare with >= so that lowering prescale mid-count ticks at once.
   always_comb begin
      tick      = (pre_cnt_q >= bus.prescale);
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      count_d  = count_q;
      period_d = period_q;
      over_d   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.stop_flag[i]) begin
            state_d[i] = ST_IDLE;
         end else if (bus.start_flag[i]) begin
            state_d[i]                  = ST_RUN;
            mode_d[i]                   = bus.mode[i];
            count_d[i*WIDTH +: WIDTH]   = bus.timer_circle[i*WIDTH +: WIDTH];
            period_d[i*WIDTH +: WIDTH]  = bus.timer_circle[i*WIDTH +: WIDTH];
         end else if (state_q[i] == ST_RUN && tick) begin
            if (count_q[i*WIDTH +: WIDTH] != '0) begin
               count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH] - CNT_ONE;
            end else begin
               over_d[i] = 1'b1;
               if (mode_q[i]) begin
                  count_d[i*WIDTH +: WIDTH] = period_q[i*WIDTH +: WIDTH];
               end else begin
                  state_d[i] = ST_IDLE;
               end
            end
         end
      end
      // Expiry outranks a same-cycle clear so no event is lost.
      status_d = over_d | (status_q & ~bus.irq_clr);
      irq_d    = |status_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pre_cnt_q <= '0;
         state_q   <= {CHANNELS{ST_IDLE}};
         mode_q    <= '0;
         count_q   <= '0;
         period_q  <= '0;
         over_q    <= '0;
         status_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         state_q   <= state_d;
         mode_q    <= mode_d;
         count_q   <= count_d;
         period_q  <= period_d;
         over_q    <= over_d;
         status_q  <= status_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.timer_over  = over_q;
   assign bus.busy        = state_q;
   assign bus.timer_value = count_q;
   assign bus.status      = status_q;
   assign bus.irq         = irq_q;
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: a one-shot vector table on channel 0 plus
// hand-written sequences for auto-reload, stop, restart, reset and irq_clr.
module tb_multi_timer;
   localparam int W = 8;
   localparam int C = 4;
   localparam int P = 4;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   multi_timer_if #(.WIDTH(W), .CHANNELS(C), .PRESCALE_W(P)) bus();

   multi_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE_W(P)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      logic       start;
      logic       clr;
      logic [3:0] exp_over;
      logic       exp_busy;
      logic [7:0] exp_val;
      logic       exp_status;
      logic       exp_irq;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_n(input int ch, input logic [7:0] n);
      bus.timer_circle[ch*W +: W] = n;
   endtask

   function automatic logic [7:0] val(input int ch);
      return bus.timer_value[ch*W +: W];
   endfunction

   // Steps until timer_over[ch] is seen; returns the number of steps taken.
   task automatic wait_pulse(input int ch, input int max, input int start_cnt,
                             input string name, output int cnt);
      cnt = start_cnt;
      do begin
         step();
         cnt++;
      end while (!bus.timer_over[ch] && cnt < max);
      if (!bus.timer_over[ch]) chk({name, " timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic seen;

      bus.timer_circle = '0;
      bus.start_flag   = '0;
      bus.stop_flag    = '0;
      bus.mode         = '0;
      bus.prescale     = '0;
      bus.irq_clr      = '0;

      // one-shot N=5 on ch0, prescale 0; then clear status
      tbl[0] = '{1'b1, 1'b0, 4'h0, 1'b1, 8'd5, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 4'h0, 1'b1, 8'd4, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 4'h0, 1'b1, 8'd3, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 4'h0, 1'b1, 8'd2, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 4'h0, 1'b1, 8'd1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 4'h0, 1'b1, 8'd0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 4'h1, 1'b0, 8'd0, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 1'b0};

      #1;
      chk("reset over",   32'(bus.timer_over),  32'd0);
      chk("reset busy",   32'(bus.busy),        32'd0);
      chk("reset value",  32'(bus.timer_value), 32'd0);
      chk("reset status", 32'(bus.status),      32'd0);
      chk("reset irq",    32'(bus.irq),         32'd0);
      repeat (2) step();
      RST = 1'b1;
      step();

      set_n(0, 8'd5);
      for (int i = 0; i < 10; i++) begin
         bus.start_flag[0] = tbl[i].start;
         bus.irq_clr[0]    = tbl[i].clr;
         step();
         chk($sformatf("vec%0d over", i),   32'(bus.timer_over), 32'(tbl[i].exp_over));
         chk($sformatf("vec%0d busy", i),   32'(bus.busy[0]),    32'(tbl[i].exp_busy));
         chk($sformatf("vec%0d value", i),  32'(val(0)),         32'(tbl[i].exp_val));
         chk($sformatf("vec%0d status", i), 32'(bus.status[0]),  32'(tbl[i].exp_status));
         chk($sformatf("vec%0d irq", i),    32'(bus.irq),        32'(tbl[i].exp_irq));
      end
      bus.start_flag = '0;
      bus.irq_clr    = '0;

      // ch1 auto-reload, prescale 3, N=2: 12-clock period
      bus.prescale = 4'd3;
      bus.mode[1]  = 1'b1;
      set_n(1, 8'd2);
      bus.start_flag[1] = 1'b1;
      step();
      bus.start_flag[1] = 1'b0;
      wait_pulse(1, 40, 0, "ch1 first pulse", cnt);
      chk("ch1 status after pulse", 32'(bus.status[1]), 32'd1);
      step();
      chk("ch1 pulse width", 32'(bus.timer_over[1]), 32'd0);
      chk("ch1 irq after pulse", 32'(bus.irq), 32'd1);
      wait_pulse(1, 40, 1, "ch1 second pulse", cnt);
      chk("ch1 period 1", 32'(cnt), 32'd12);
      wait_pulse(1, 40, 0, "ch1 third pulse", cnt);
      chk("ch1 period 2", 32'(cnt), 32'd12);
      bus.irq_clr[1] = 1'b1;
      step();
      bus.irq_clr[1] = 1'b0;
      chk("ch1 status cleared", 32'(bus.status[1]), 32'd0);
      chk("ch1 irq lags clear", 32'(bus.irq), 32'd1);
      step();
      chk("ch1 irq cleared", 32'(bus.irq), 32'd0);
      wait_pulse(1, 40, 2, "ch1 fourth pulse", cnt);
      chk("ch1 period 3", 32'(cnt), 32'd12);
      chk("ch1 status re-set", 32'(bus.status[1]), 32'd1);
      bus.stop_flag[1] = 1'b1;
      step();
      bus.stop_flag[1] = 1'b0;
      bus.mode[1]      = 1'b0;
      chk("ch1 stopped", 32'(bus.busy[1]), 32'd0);
      bus.irq_clr = '1;
      step();
      bus.irq_clr  = '0;
      bus.prescale = 4'd0;
      step();

      // ch2 stop at count 4, then N=0 restart
      set_n(2, 8'd10);
      bus.start_flag[2] = 1'b1;
      step();
      bus.start_flag[2] = 1'b0;
      chk("ch2 loaded", 32'(val(2)), 32'd10);
      repeat (6) step();
      chk("ch2 count 4", 32'(val(2)), 32'd4);
      bus.stop_flag[2] = 1'b1;
      step();
      bus.stop_flag[2] = 1'b0;
      chk("ch2 busy after stop", 32'(bus.busy[2]), 32'd0);
      seen = 1'b0;
      repeat (6) begin
         step();
         seen |= bus.timer_over[2];
      end
      chk("ch2 held value", 32'(val(2)), 32'd4);
      chk("ch2 no pulse after stop", 32'(seen), 32'd0);
      set_n(2, 8'd0);
      bus.start_flag[2] = 1'b1;
      step();
      bus.start_flag[2] = 1'b0;
      chk("ch2 N0 busy", 32'(bus.busy[2]), 32'd1);
      chk("ch2 N0 no early pulse", 32'(bus.timer_over[2]), 32'd0);
      step();
      chk("ch2 N0 pulse", 32'(bus.timer_over[2]), 32'd1);
      chk("ch2 N0 idle", 32'(bus.busy[2]), 32'd0);

      // ch3 restart at count 1, then stop+start together
      set_n(3, 8'd8);
      bus.start_flag[3] = 1'b1;
      step();
      bus.start_flag[3] = 1'b0;
      repeat (7) step();
      chk("ch3 count 1", 32'(val(3)), 32'd1);
      set_n(3, 8'd3);
      bus.start_flag[3] = 1'b1;
      step();
      bus.start_flag[3] = 1'b0;
      chk("ch3 restart value", 32'(val(3)), 32'd3);
      seen = 1'b0;
      repeat (3) begin
         step();
         seen |= bus.timer_over[3];
      end
      chk("ch3 no old pulse", 32'(seen), 32'd0);
      chk("ch3 count 0", 32'(val(3)), 32'd0);
      step();
      chk("ch3 restart pulse", 32'(bus.timer_over[3]), 32'd1);
      set_n(3, 8'd5);
      bus.start_flag[3] = 1'b1;
      step();
      chk("ch3 running again", 32'(bus.busy[3]), 32'd1);
      bus.stop_flag[3] = 1'b1;
      step();
      bus.start_flag[3] = 1'b0;
      bus.stop_flag[3]  = 1'b0;
      chk("ch3 stop wins busy", 32'(bus.busy[3]), 32'd0);
      chk("ch3 stop wins value", 32'(val(3)), 32'd5);
      bus.irq_clr = '1;
      step();
      bus.irq_clr = '0;

      // all channels auto-reload N=7, then async reset mid-count
      bus.mode = '1;
      for (int ch = 0; ch < C; ch++) set_n(ch, 8'd7);
      bus.start_flag = '1;
      step();
      bus.start_flag = '0;
      seen = 1'b0;
      repeat (7) begin
         step();
         seen |= |bus.timer_over;
      end
      chk("all no early pulse", 32'(seen), 32'd0);
      step();
      chk("all simultaneous pulse", 32'(bus.timer_over), 32'hF);
      repeat (3) step();
      chk("all irq set", 32'(bus.irq), 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("async rst over",   32'(bus.timer_over),  32'd0);
      chk("async rst busy",   32'(bus.busy),        32'd0);
      chk("async rst value",  32'(bus.timer_value), 32'd0);
      chk("async rst status", 32'(bus.status),      32'd0);
      chk("async rst irq",    32'(bus.irq),         32'd0);
      repeat (2) step();
      RST = 1'b1;
      bus.mode = '0;
      seen = 1'b0;
      repeat (12) begin
         step();
         seen |= |bus.timer_over;
      end
      chk("no pulse after reset", 32'(seen), 32'd0);
      chk("idle after reset", 32'(bus.busy), 32'd0);

      // irq_clr coinciding with expiry on ch0
      set_n(0, 8'd2);
      bus.start_flag[0] = 1'b1;
      step();
      bus.start_flag[0] = 1'b0;
      repeat (2) step();
      bus.irq_clr[0] = 1'b1;
      step();
      bus.irq_clr[0] = 1'b0;
      chk("clr+expiry pulse", 32'(bus.timer_over[0]), 32'd1);
      chk("clr+expiry status", 32'(bus.status[0]), 32'd1);
      step();
      chk("clr+expiry irq", 32'(bus.irq), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
